// File: rtl/dp_argmax_classifier.sv
// dp_argmax_classifier
//   Consumes one signed dot-product value per class (class 0 first) and
//   reports the index and value of the frame maximum. Ties keep the lowest
//   index. A frame closes on in_last or after CLASS_N values, whichever comes
//   first; a mismatch between the two raises out_err for that frame. The
//   result is held until the consumer accepts it.
// Ports:
//   clk, GlobalReset          clock, asynchronous active-high reset
//   in_valid/in_ready         input handshake
//   in_value, in_last         signed value for the current class, frame end
//   out_valid/out_ready       result handshake
//   out_class, out_max        winning class index and its value
//   out_err                   framing error on the reported frame
module dp_argmax_classifier #(
  parameter int CLASS_N  = 10,
  parameter int VAL_SIZE = 26,
  parameter int IDX_SIZE = 4
) (
  input  logic                clk,
  input  logic                GlobalReset,
  input  logic                in_valid,
  output logic                in_ready,
  input  logic [VAL_SIZE-1:0] in_value,
  input  logic                in_last,
  output logic                out_valid,
  input  logic                out_ready,
  output logic [IDX_SIZE-1:0] out_class,
  output logic [VAL_SIZE-1:0] out_max,
  output logic                out_err
);

  typedef enum logic {
    ACCUM  = 1'b0,
    RESULT = 1'b1
  } state_t;

  localparam logic [IDX_SIZE-1:0] LAST_CNT = IDX_SIZE'(CLASS_N - 1);

  state_t              r_state;
  state_t              w_state_nxt;
  logic                r_rdy_en;
  logic [IDX_SIZE-1:0] r_cnt;
  logic [IDX_SIZE-1:0] r_idx;
  logic [VAL_SIZE-1:0] r_max;
  logic [IDX_SIZE-1:0] r_out_class;
  logic [VAL_SIZE-1:0] r_out_max;
  logic                r_out_err;

  logic                w_accept;
  logic                w_at_end;
  logic                w_close;
  logic                w_ack;
  logic                w_take;
  logic [VAL_SIZE-1:0] w_win_val;
  logic [IDX_SIZE-1:0] w_win_idx;

  // Accept is derived from state directly rather than from in_ready so the
  // next-state logic below has no path back through its own output.
  assign w_accept  = in_valid & r_rdy_en & (r_state == ACCUM);
  assign w_at_end  = (r_cnt == LAST_CNT);
  assign w_close   = w_accept & (in_last | w_at_end);
  assign w_ack     = (r_state == RESULT) & out_ready;

  // First value of a frame always wins; afterwards only a strictly larger one.
  assign w_take    = (r_cnt == '0) | ($signed(in_value) > $signed(r_max));
  assign w_win_val = w_take ? in_value : r_max;
  assign w_win_idx = w_take ? r_cnt : r_idx;

  always_ff @(posedge clk or posedge GlobalReset) begin
    if (GlobalReset) begin
      r_state  <= ACCUM;
      r_rdy_en <= 1'b0;
    end else begin
      r_state  <= w_state_nxt;
      r_rdy_en <= 1'b1;
    end
  end

  always_comb begin
    w_state_nxt = r_state;
    in_ready    = 1'b0;
    out_valid   = 1'b0;
    case (r_state)
      ACCUM: begin
        in_ready = r_rdy_en;
        if (w_close) w_state_nxt = RESULT;
      end
      RESULT: begin
        out_valid = 1'b1;
        if (out_ready) w_state_nxt = ACCUM;
      end
      default: w_state_nxt = ACCUM;
    endcase
  end

  always_ff @(posedge clk or posedge GlobalReset) begin
    if (GlobalReset) begin
      r_cnt       <= '0;
      r_idx       <= '0;
      r_max       <= '0;
      r_out_class <= '0;
      r_out_max   <= '0;
      r_out_err   <= 1'b0;
    end else begin
      if (w_accept) begin
        r_max <= w_win_val;
        r_idx <= w_win_idx;
        r_cnt <= w_close ? '0 : r_cnt + 1'b1;
      end
      if (w_close) begin
        r_out_class <= w_win_idx;
        r_out_max   <= w_win_val;
        r_out_err   <= in_last ^ w_at_end;
      end
      if (w_ack) begin
        r_cnt     <= '0;
        r_out_err <= 1'b0;
      end
    end
  end

  assign out_class = r_out_class;
  assign out_max   = r_out_max;
  assign out_err   = r_out_err;

endmodule

// File: doc/dp_argmax_classifier.md
Name: dp_argmax_classifier

Overview:
- Downstream consumer of the dot-product stage.
- Accepts one dot-product result per class (CLASS_N values per frame, class 0 first) over a valid/ready handshake.
- Tracks the running signed maximum and presents the winning class index and its score once the frame completes.
- Output is held until the consumer acknowledges it.

Parameters:
CLASS_N, 10, number of dot-product values (classes) per frame; must be >= 2
VAL_SIZE, 26, width of each dot-product value, two's-complement signed fixed point
IDX_SIZE, 4, width of the class index; must satisfy 2^IDX_SIZE >= CLASS_N

Ports:
clk  input  1  system clock, all state updates on rising edge
GlobalReset  input  1  asynchronous, active-high reset
in_valid  input  1  in_value/in_last are valid this cycle
in_ready  output  1  block can accept an input this cycle
in_value  input  VAL_SIZE  dot-product value for the current class, signed
in_last  input  1  marks the final value of a frame
out_valid  output  1  result is valid and held
out_ready  input  1  consumer accepts the result this cycle
out_class  output  IDX_SIZE  index of the maximum value within the frame
out_max  output  VAL_SIZE  maximum value within the frame, signed
out_err  output  1  framing error on this frame

Behaviour:
- Reset (async, GlobalReset=1): state=ACCUM, cnt=0, max=0, out_class=0, out_max=0, out_valid=0, out_err=0, err_pend=0. in_ready=1 one cycle after reset deasserts.
- Reset mid-frame or mid-result discards all state; no partial result is emitted.
- Accept event: in_valid & in_ready at a rising edge.
- State ACCUM:
  - in_ready=1, out_valid=0.
  - On accept with cnt==0: max<=in_value, idx<=0.
  - On accept with cnt>0: if $signed(in_value) > $signed(max) (strict), max<=in_value and idx<=cnt; otherwise hold.
  - Ties therefore keep the lowest index.
  - cnt increments on each accept.
- Frame close:
  - The frame closes on the accept where in_last=1 or cnt==CLASS_N-1, whichever occurs first.
  - On that edge the state goes to RESULT, and out_class/out_max load the final winner, including the value accepted on that edge.
  - out_err=1 if in_last=1 with cnt!=CLASS_N-1 (short frame), or if cnt==CLASS_N-1 with in_last=0 (missing last).
  - In the missing-last case the frame still closes, and the next input starts a new frame.
- State RESULT:
  - out_valid=1, in_ready=0.
  - out_class, out_max and out_err are stable while out_valid=1 and out_ready=0.
  - On out_valid & out_ready: state=ACCUM, cnt=0, out_valid=0 on the following cycle, out_err cleared.
  - out_class/out_max hold their last value until overwritten by the next frame close.
- Latency: out_valid rises on the clock edge that accepts the final value, so it is visible the cycle after that value is presented. Minimum frame period is CLASS_N + 1 cycles with out_ready tied high.
- No accept can occur in RESULT because in_ready=0. Input presented with in_valid=1 is held by the producer until in_ready returns.
- Arithmetic: comparison only, no extension or saturation. Full VAL_SIZE signed compare. The most negative value is a legal input.
- in_value/in_last are ignored whenever in_valid=0. X on in_value when in_valid=0 must not corrupt state.

Test Plan:
1. CLASS_N=10, in_valid held high; values 5,3,9,-2,9,0,1,7,8,4 with in_last on the 10th; out_ready=1 -> out_valid=1 for one cycle, out_class=2 (tie at 4 keeps 2), out_max=9, out_err=0, next accept the following cycle.
2. All negative values -100..-109 (class k = -100-k) -> out_class=0, out_max=-100. Then a frame of all equal 0x2000000 (most negative) -> out_class=0, out_max=0x2000000.
3. Backpressure: complete a frame, hold out_ready=0 for 20 cycles while in_valid=1 -> in_ready=0 and outputs stable throughout. Raise out_ready -> one handshake, then in_ready=1 next cycle and the pending input is accepted.
4. Short frame: 4 values 1,6,2,3 with in_last on the 4th -> out_err=1, out_class=1, out_max=6. The following normal frame reports out_err=0.
5. Missing last: 10 values with in_last=0 throughout -> frame closes after the 10th with out_err=1. The 11th value is counted as class 0 of a new frame.
6. Reset mid-frame after 5 accepts -> out_valid stays 0. A subsequent full frame with max at index 7 reports out_class=7, proving cnt and max were cleared; in_valid toggled randomly gives identical results.
